timer_ctrl: RTL

//  APB-slave control block for timer_counter; owns its en/load/dw/ld_val and clk_sel sel inputs.

---
 rtl/timer_ctrl_if.sv | 24 ++
 rtl/timer_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl_if.sv
// APB slave bus bundle for timer_ctrl: master drives the request, slave returns data/ready/error.
interface timer_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/timer_ctrl.sv
// APB control block for timer_counter/clk_sel: register file, clk_int-paced load sequencer, wrap flags.
// Optional TIER register and irq output are built only when TIMER_IRQ_EN is defined.
module timer_ctrl #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int LD_TIMEOUT = 64
) (
    input  logic              pclk,
    input  logic              presetn,
    timer_ctrl_if.slave       apb,
    input  logic              clk_int,
    input  logic [DATA_W-1:0] cnt_out,
    output logic              en,
    output logic              load,
    output logic              dw,
    output logic [DATA_W-1:0] ld_val,
    output logic [1:0]        sel,
    output logic              irq
);
    localparam int                CNT_W    = (LD_TIMEOUT > 1) ? $clog2(LD_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  LD_LAST  = CNT_W'(LD_TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] A_TCR    = ADDR_W'(8'h00);
    localparam logic [ADDR_W-1:0] A_TDR    = ADDR_W'(8'h04);
    localparam logic [ADDR_W-1:0] A_TSR    = ADDR_W'(8'h08);
    localparam logic [ADDR_W-1:0] A_TIER   = ADDR_W'(8'h0C);
    localparam logic [ADDR_W-1:0] A_TCNT   = ADDR_W'(8'h10);
    localparam logic [DATA_W-1:0] ALL_ONES = '1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS}       apb_state_t;
    typedef enum logic [1:0] {LD_IDLE, LD_WAIT, LD_HOLD} ld_state_t;

    apb_state_t        r_apb_state, w_apb_next;
    ld_state_t         r_ld_state, w_ld_next;
    logic [CNT_W-1:0]  r_ld_cnt;
    logic              r_en, r_dw, r_clk_int_d, r_busy_d;
    logic [1:0]        r_sel;
    logic [DATA_W-1:0] r_ld_val, r_cnt_d;
    logic [2:0]        r_tsr, w_tier, w_tsr_set, w_tsr_clr;
    logic              w_access, w_wr, w_busy, w_rise, w_ld_start, w_ld_timeout;
    logic              w_quiet, w_ovf, w_udf, w_err;
    logic              w_hit_tcr, w_hit_tdr, w_hit_tsr, w_hit_tier, w_hit_tcnt;
    logic [DATA_W-1:0] w_rdata;

    always_ff @(posedge pclk) begin
        if (!presetn) r_apb_state <= IDLE;
        else          r_apb_state <= w_apb_next;
    end

    always_comb begin
        w_apb_next = r_apb_state;
        case (r_apb_state)
            IDLE:    if (apb.psel && !apb.penable) w_apb_next = SETUP;
            SETUP:   w_apb_next = (apb.psel && apb.penable) ? ACCESS : IDLE;
            ACCESS:  w_apb_next = IDLE;
            default: w_apb_next = IDLE;
        endcase
    end

    assign w_access   = (r_apb_state == ACCESS);
    assign w_wr       = w_access & apb.pwrite;
    assign w_hit_tcr  = (apb.paddr == A_TCR);
    assign w_hit_tdr  = (apb.paddr == A_TDR);
    assign w_hit_tsr  = (apb.paddr == A_TSR);
    assign w_hit_tier = (apb.paddr == A_TIER);
    assign w_hit_tcnt = (apb.paddr == A_TCNT);

    always_comb begin
        w_err   = 1'b0;
        w_rdata = '0;
        if (w_access) begin
            if (w_hit_tcr) begin
                w_err   = apb.pwrite & apb.pwdata[4] & w_busy;
                w_rdata = DATA_W'({w_busy, r_sel, r_dw, r_en});
            end else if (w_hit_tdr) begin
                w_err   = apb.pwrite & w_busy;
                w_rdata = r_ld_val;
            end else if (w_hit_tsr) begin
                w_rdata = DATA_W'(r_tsr);
            end else if (w_hit_tier) begin
                w_rdata = DATA_W'(w_tier);
            end else if (w_hit_tcnt) begin
                w_err   = apb.pwrite;
                w_rdata = cnt_out;
            end else begin
                w_err   = 1'b1;
            end
            if (apb.pwrite) w_rdata = '0;
        end
    end

    assign apb.prdata  = w_rdata;
    assign apb.pready  = w_access;
    assign apb.pslverr = w_err;

    // Load sequencer: strobe spans two clk_int rising edges so the slow counter clock samples it.
    assign w_busy     = (r_ld_state != LD_IDLE);
    assign w_rise     = clk_int & ~r_clk_int_d;
    assign w_ld_start = w_wr & w_hit_tcr & apb.pwdata[4] & ~w_busy;

    always_comb begin
        w_ld_next    = r_ld_state;
        w_ld_timeout = 1'b0;
        case (r_ld_state)
            LD_IDLE: if (w_ld_start) w_ld_next = LD_WAIT;
            LD_WAIT: begin
                if (w_rise) begin
                    w_ld_next = LD_HOLD;
                end else if (r_ld_cnt == LD_LAST) begin
                    w_ld_next    = LD_IDLE;
                    w_ld_timeout = 1'b1;
                end
            end
            LD_HOLD: if (w_rise) w_ld_next = LD_IDLE;
            default: w_ld_next = LD_IDLE;
        endcase
    end

    // A load forces arbitrary counter jumps, so wrap detection stays off until one cycle after it ends.
    assign w_quiet   = ~w_busy & ~r_busy_d;
    assign w_ovf     = w_quiet & ~r_dw & (r_cnt_d == ALL_ONES) & (cnt_out == '0);
    assign w_udf     = w_quiet & r_dw & (r_cnt_d == '0) & (cnt_out == ALL_ONES);
    assign w_tsr_set = {w_ld_timeout, w_udf, w_ovf};
    assign w_tsr_clr = (w_wr && w_hit_tsr) ? apb.pwdata[2:0] : 3'b000;

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_ld_state  <= LD_IDLE;
            r_ld_cnt    <= '0;
            r_en        <= 1'b0;
            r_dw        <= 1'b0;
            r_sel       <= 2'b00;
            r_ld_val    <= '0;
            r_cnt_d     <= '0;
            r_tsr       <= 3'b000;
            r_clk_int_d <= 1'b0;
            r_busy_d    <= 1'b0;
        end else begin
            r_ld_state  <= w_ld_next;
            r_ld_cnt    <= (r_ld_state == LD_WAIT) ? r_ld_cnt + CNT_W'(1) : '0;
            r_clk_int_d <= clk_int;
            r_cnt_d     <= cnt_out;
            r_busy_d    <= w_busy;
            if (w_wr && w_hit_tcr) begin
                r_en  <= apb.pwdata[0];
                r_dw  <= apb.pwdata[1];
                r_sel <= apb.pwdata[3:2];
            end
            if (w_wr && w_hit_tdr && !w_busy) r_ld_val <= apb.pwdata;
            r_tsr <= (r_tsr & ~w_tsr_clr) | w_tsr_set;
        end
    end

`ifdef TIMER_IRQ_EN
    logic [2:0] r_tier;
    logic       r_irq;

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_tier <= 3'b000;
            r_irq  <= 1'b0;
        end else begin
            if (w_wr && w_hit_tier) r_tier <= apb.pwdata[2:0];
            r_irq <= |(r_tsr & r_tier);
        end
    end

    assign w_tier = r_tier;
    assign irq    = r_irq;
`else
    assign w_tier = 3'b000;
    assign irq    = 1'b0;
`endif

    assign en     = r_en;
    assign dw     = r_dw;
    assign sel    = r_sel;
    assign ld_val = r_ld_val;
    assign load   = w_busy;
endmodule
